// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants and types for the ALU-sharing arbiter: opcode encodings,
// datapath width and the response-buffer state type.
package alu_share_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_AND  = 5'd2;
  localparam logic [OP_W-1:0] OP_OR   = 5'd3;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd4;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd5;
  localparam logic [OP_W-1:0] OP_LAST = 5'd5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// accepted index and wraps, yielding a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last) + k) % NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters via round-robin
// arbitration, capturing tagged results in a one-entry response buffer.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_opcode,
  input  logic [5*NUM_REQ-1:0]      req_shamt,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_ne,
  output logic                      rsp_lt,
  output logic                      rsp_ovf,
  output logic                      rsp_err,
  output logic [CNT_W-1:0]          op_count
);

  buf_state_t          state_q, state_d;
  logic [ID_W-1:0]     last_q;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                can_accept, accept;

  logic [OP_W-1:0]     op_sel;
  logic [4:0]          shamt_sel;
  logic [DATA_W-1:0]   a_sel, b_sel, sum, diff;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_ne, alu_lt, alu_ovf, alu_err;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign accept     = reset_n && can_accept && grant_any;
  assign req_ready  = (reset_n && can_accept) ? grant : '0;
  assign rsp_valid  = (state_q == FULL);

  // AND-OR payload mux driven by the one-hot grant
  always_comb begin
    op_sel    = '0;
    shamt_sel = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_sel    = req_opcode[i*OP_W +: OP_W];
        shamt_sel = req_shamt[i*5 +: 5];
        a_sel     = req_a[i*DATA_W +: DATA_W];
        b_sel     = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Flags are masked to the opcodes that define them; illegal opcodes bypass the ALU
  always_comb begin
    sum        = a_sel + b_sel;
    diff       = a_sel - b_sel;
    alu_result = '0;
    alu_ne     = 1'b0;
    alu_lt     = 1'b0;
    alu_ovf    = 1'b0;
    alu_err    = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (a_sel[DATA_W-1] == b_sel[DATA_W-1]) && (sum[DATA_W-1] != a_sel[DATA_W-1]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (a_sel[DATA_W-1] != b_sel[DATA_W-1]) && (diff[DATA_W-1] != a_sel[DATA_W-1]);
        alu_ne     = |diff;
        alu_lt     = diff[DATA_W-1] ^ alu_ovf;
      end
      OP_AND: alu_result = a_sel & b_sel;
      OP_OR:  alu_result = a_sel | b_sel;
      OP_SLL: alu_result = a_sel << shamt_sel;
      OP_SRA: alu_result = $signed(a_sel) >>> shamt_sel;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (!accept && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      last_q     <= ID_W'(NUM_REQ - 1);
      op_count   <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_ne     <= 1'b0;
      rsp_lt     <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q     <= grant_idx;
        op_count   <= op_count + 1'b1;
        rsp_id     <= grant_idx;
        rsp_result <= alu_result;
        rsp_ne     <= alu_ne;
        rsp_lt     <= alu_lt;
        rsp_ovf    <= alu_ovf;
        rsp_err    <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_alu_share_arbiter;

  localparam int N     = 2;
  localparam int ID_W  = 1;
  localparam int CNT_W = 16;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  typedef struct {
    logic [31:0] res;
    bit ne, lt, ovf, err;
  } rsp_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [5*N-1:0]   req_opcode, req_shamt;
  logic [32*N-1:0]  req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [31:0]      rsp_result;
  logic             rsp_ne, rsp_lt, rsp_ovf, rsp_err;
  logic [CNT_W-1:0] op_count;

  bit          pend_v[N];
  logic [4:0]  pend_op[N], pend_sh[N];
  logic [31:0] pend_a[N], pend_b[N];

  bit   m_full;
  int   m_id, m_last, m_count;
  rsp_t m_rsp;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  alu_share_arbiter #(
    .NUM_REQ (N),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_shamt  (req_shamt),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ne     (rsp_ne),
    .rsp_lt     (rsp_lt),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  always_comb begin
    req_valid  = '0;
    req_opcode = '0;
    req_shamt  = '0;
    req_a      = '0;
    req_b      = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend_v[i];
      req_opcode[i*5 +: 5] = pend_op[i];
      req_shamt[i*5 +: 5]  = pend_sh[i];
      req_a[i*32 +: 32]    = pend_a[i];
      req_b[i*32 +: 32]    = pend_b[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t ref_alu(input logic [4:0] op, input logic [4:0] sh,
                                   input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    longint sa, sb, s;
    r = '{res: 32'd0, ne: 1'b0, lt: 1'b0, ovf: 1'b0, err: 1'b0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (int'(op))
      0: begin s = sa + sb; r.res = a + b; r.ovf = (s > MAXI) || (s < MINI); end
      1: begin
        s = sa - sb; r.res = a - b; r.ovf = (s > MAXI) || (s < MINI);
        r.ne = (a != b); r.lt = (sa < sb);
      end
      2: r.res = a & b;
      3: r.res = a | b;
      4: r.res = a << sh;
      5: r.res = $signed(a) >>> sh;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic int exp_grant();
    for (int k = 1; k <= N; k++) begin
      int c = (m_last + k) % N;
      if (pend_v[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit can_take();
    return reset_n && (exp_grant() >= 0) && (!m_full || rsp_ready);
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_id = 0; m_last = N - 1; m_count = 0;
    m_rsp = '{res: 32'd0, ne: 1'b0, lt: 1'b0, ovf: 1'b0, err: 1'b0};
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
    pend_v[i] = 1'b1; pend_op[i] = op; pend_sh[i] = sh; pend_a[i] = a; pend_b[i] = b;
  endtask

  // One clock edge: predict accept/drain from the model, then advance it
  task automatic step(output bit acc, output int g);
    bit drain;
    g     = exp_grant();
    acc   = can_take();
    drain = m_full && rsp_ready;
    @(posedge clock);
    #1;
    if (acc) begin
      m_rsp = ref_alu(pend_op[g], pend_sh[g], pend_a[g], pend_b[g]);
      m_id = g; m_full = 1'b1; m_last = g; m_count++;
      pend_v[g] = 1'b0;
    end else if (drain) begin
      m_full = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      int g;
      logic [N-1:0] er;
      g  = exp_grant();
      er = can_take() ? N'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      chk("op_count", 32'(op_count), m_count & 32'h0000FFFF);
      if (m_full) begin
        chk("rsp_id", 32'(rsp_id), m_id);
        chk("rsp_result", rsp_result, m_rsp.res);
        chk("rsp_ne", 32'(rsp_ne), 32'(m_rsp.ne));
        chk("rsp_lt", 32'(rsp_lt), 32'(m_rsp.lt));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(m_rsp.ovf));
        chk("rsp_err", 32'(rsp_err), 32'(m_rsp.err));
      end
    end
  end

  function automatic logic [31:0] rand_word();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    if ($urandom_range(7) == 0) return 5'($urandom_range(31));
    return 5'($urandom_range(5));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int g;
    int ids[4];

    for (int i = 0; i < N; i++) set_req(i, 5'd0, 5'd0, 32'd0, 32'd0);
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset op_count", 32'(op_count), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("reset rsp_err", 32'(rsp_err), 0);
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Requester 0 ADD overflow
    set_req(0, 5'd0, 5'd0, 32'h40000000, 32'h40000000);
    rsp_ready = 1'b1;
    step(acc, g);
    chk("t1 accepted", 32'(acc), 1);
    chk("t1 rsp_valid", 32'(rsp_valid), 1);
    chk("t1 rsp_result", rsp_result, 32'h80000000);
    chk("t1 rsp_ovf", 32'(rsp_ovf), 1);
    chk("t1 rsp_id", 32'(rsp_id), 0);
    chk("t1 op_count", 32'(op_count), 1);

    // Requester 1 signed SUB
    set_req(1, 5'd1, 5'd0, 32'h80000001, 32'h7FFFFFFF);
    step(acc, g);
    chk("t2 rsp_id", 32'(rsp_id), 1);
    chk("t2 rsp_lt", 32'(rsp_lt), 1);
    chk("t2 rsp_ne", 32'(rsp_ne), 1);
    chk("t2 rsp_ovf", 32'(rsp_ovf), 1);
    chk("t2 rsp_result", rsp_result, 32'h00000002);

    // Both valid continuously: alternating grants
    for (int i = 0; i < N; i++) set_req(i, 5'd0, 5'd0, $urandom, $urandom);
    for (int c = 0; c < 4; c++) begin
      step(acc, g);
      ids[c] = g;
      set_req(g, 5'd0, 5'd0, $urandom, $urandom);
    end
    chk("t3 id0", ids[0], 0);
    chk("t3 id1", ids[1], 1);
    chk("t3 id2", ids[2], 0);
    chk("t3 id3", ids[3], 1);
    chk("t3 op_count", 32'(op_count), 6);

    // Backpressure for three cycles, then drain and accept together
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(acc, g);
      chk("t4 held req_ready", 32'(req_ready), 0);
      chk("t4 held rsp_id", 32'(rsp_id), 1);
      chk("t4 held op_count", 32'(op_count), 6);
    end
    rsp_ready = 1'b1;
    step(acc, g);
    chk("t4 release grant", g, 0);
    chk("t4 release op_count", 32'(op_count), 7);
    chk("t4 release rsp_valid", 32'(rsp_valid), 1);

    for (int c = 0; c < 8; c++) begin
      if (pend_v[0] || pend_v[1] || m_full) step(acc, g);
    end

    // Illegal opcode, then SLL by 31
    set_req(0, 5'b00111, 5'd3, 32'hDEADBEEF, 32'h12345678);
    step(acc, g);
    chk("t5 err", 32'(rsp_err), 1);
    chk("t5 result", rsp_result, 0);
    chk("t5 flags", {29'd0, rsp_ne, rsp_lt, rsp_ovf}, 0);
    set_req(0, 5'd4, 5'd31, 32'h1, $urandom);
    step(acc, g);
    chk("t5 sll result", rsp_result, 32'h80000000);
    chk("t5 sll err", 32'(rsp_err), 0);

    // Reset while FULL
    set_req(0, 5'd3, 5'd0, $urandom, $urandom);
    set_req(1, 5'd2, 5'd0, $urandom, $urandom);
    step(acc, g);
    #2;
    cmp_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6 rsp_valid", 32'(rsp_valid), 0);
    chk("t6 op_count", 32'(op_count), 0);
    chk("t6 req_ready", 32'(req_ready), 0);
    model_reset();
    set_req(0, 5'd0, 5'd0, 32'd5, 32'd7);
    set_req(1, 5'd1, 5'd0, $urandom, $urandom);
    @(posedge clock); #1;
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    step(acc, g);
    chk("t6 first grant", g, 0);
    chk("t6 rsp_id", 32'(rsp_id), 0);
    chk("t6 rsp_result", rsp_result, 32'd12);
    chk("t6 op_count", 32'(op_count), 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(99) < 60)
          set_req(i, rand_op(), 5'($urandom_range(31)), rand_word(), rand_word());
      rsp_ready = ($urandom_range(99) < 70);
      step(acc, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
